// File: rtl/game_pkg.sv
// Shared types and constants for the player health / score slice.
package game_pkg;

  localparam int HP_W = 4;
  localparam int SCORE_DIGITS = 4;
  localparam int CNT_W = 8;
  localparam int DEF_MAX_HP = 5;
  localparam int DEF_INVULN_FRAMES = 60;

  typedef enum logic [1:0] {
    ALIVE,
    INVULN,
    DEAD
  } player_state_t;

  // One BCD digit add: returns {carry_out, digit}.
  function automatic logic [4:0] bcd_add(
    input logic [3:0] a,
    input logic [3:0] b,
    input logic       ci
  );
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b} + {4'b0, ci};
    if (s > 5'd9) begin
      s = s - 5'd10;
      return {1'b1, s[3:0]};
    end
    return {1'b0, s[3:0]};
  endfunction

endpackage

// File: rtl/player_status_if.sv
// Event inputs from gameplay and status outputs to controller/display.
interface player_status_if;
  import game_pkg::*;

  logic            game_reset;
  logic            score_reset;
  logic            frame_tick;
  logic            hit_1;
  logic            hit_2;
  logic            points;
  logic [3:0]      points_val;
  logic [HP_W-1:0] hp_1;
  logic [HP_W-1:0] hp_2;
  logic            dead_1;
  logic            dead_2;
  logic            invuln_1;
  logic            invuln_2;
  logic [15:0]     score_bcd;
  logic            score_max;

  modport master (
    output game_reset, score_reset, frame_tick,
    output hit_1, hit_2, points, points_val,
    input  hp_1, hp_2, dead_1, dead_2,
    input  invuln_1, invuln_2, score_bcd, score_max
  );

  modport slave (
    input  game_reset, score_reset, frame_tick,
    input  hit_1, hit_2, points, points_val,
    output hp_1, hp_2, dead_1, dead_2,
    output invuln_1, invuln_2, score_bcd, score_max
  );

endinterface

// File: rtl/player_status_health.sv
// One player's ALIVE/INVULN/DEAD FSM with HP and
// frame-based invulnerability counter.
module player_health
  import game_pkg::*;
#(
  parameter int MAX_HP        = DEF_MAX_HP,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input  logic            Clk,
  input  logic            Reset,
  input  logic            game_reset,
  input  logic            hit,
  input  logic            frame_tick,
  output logic [HP_W-1:0] hp,
  output logic            dead,
  output logic            invuln
);

  player_state_t    state_q, state_d;
  logic [HP_W-1:0]  hp_q, hp_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // State, HP and counter registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q <= ALIVE;
      hp_q    <= HP_W'(MAX_HP);
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      hp_q    <= hp_d;
      cnt_q   <= cnt_d;
    end
  end

  // Next state: game_reset beats hit beats tick
  always_comb begin
    state_d = state_q;
    hp_d    = hp_q;
    cnt_d   = cnt_q;
    if (game_reset) begin
      state_d = ALIVE;
      hp_d    = HP_W'(MAX_HP);
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        ALIVE: begin
          if (hit) begin
            if (hp_q > HP_W'(1)) begin
              hp_d    = hp_q - HP_W'(1);
              cnt_d   = CNT_W'(INVULN_FRAMES);
              state_d = INVULN;
            end else begin
              hp_d    = '0;
              state_d = DEAD;
            end
          end
        end
        INVULN: begin
          if (frame_tick) begin
            if (cnt_q == CNT_W'(1)) begin
              cnt_d   = '0;
              state_d = ALIVE;
            end else begin
              cnt_d = cnt_q - CNT_W'(1);
            end
          end
        end
        DEAD: begin
        end
        default: state_d = ALIVE;
      endcase
    end
  end

  assign hp     = hp_q;
  assign dead   = (state_q == DEAD);
  assign invuln = (state_q == INVULN);

endmodule

// File: rtl/player_status.sv
// Two-player health tracking plus shared saturating
// 4-digit BCD score.
module player_status
  import game_pkg::*;
#(
  parameter int MAX_HP        = DEF_MAX_HP,
  parameter int INVULN_FRAMES = DEF_INVULN_FRAMES
) (
  input  logic          Clk,
  input  logic          Reset,
  player_status_if.slave bus
);

  localparam logic [15:0] SCORE_TOP = 16'h9999;

  logic [15:0] score_q, score_d;
  logic        max_q, max_d;
  logic [15:0] sum;
  logic        carry;
  logic [3:0]  add_val;

  player_health #(
    .MAX_HP       (MAX_HP),
    .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p1 (
    .Clk       (Clk),
    .Reset     (Reset),
    .game_reset(bus.game_reset),
    .hit       (bus.hit_1),
    .frame_tick(bus.frame_tick),
    .hp        (bus.hp_1),
    .dead      (bus.dead_1),
    .invuln    (bus.invuln_1)
  );

  player_health #(
    .MAX_HP       (MAX_HP),
    .INVULN_FRAMES(INVULN_FRAMES)
  ) u_p2 (
    .Clk       (Clk),
    .Reset     (Reset),
    .game_reset(bus.game_reset),
    .hit       (bus.hit_2),
    .frame_tick(bus.frame_tick),
    .hp        (bus.hp_2),
    .dead      (bus.dead_2),
    .invuln    (bus.invuln_2)
  );

  // Score registers
  always_ff @(posedge Clk) begin
    if (Reset) begin
      score_q <= '0;
      max_q   <= 1'b0;
    end else begin
      score_q <= score_d;
      max_q   <= max_d;
    end
  end

  // Ripple BCD add of the clamped award
  always_comb begin
    add_val = (bus.points_val > 4'd9) ? 4'd9 : bus.points_val;
    carry   = 1'b0;
    sum     = '0;
    for (int i = 0; i < SCORE_DIGITS; i++) begin
      {carry, sum[i*4 +: 4]} = bcd_add(
        score_q[i*4 +: 4],
        (i == 0) ? add_val : 4'd0,
        carry);
    end
  end

  // Score next state: clear beats award, saturate at 9999
  always_comb begin
    score_d = score_q;
    max_d   = max_q;
    if (bus.score_reset) begin
      score_d = '0;
      max_d   = 1'b0;
    end else if (bus.points && !(bus.dead_1 && bus.dead_2)) begin
      if (carry || sum == SCORE_TOP) begin
        score_d = SCORE_TOP;
        max_d   = 1'b1;
      end else begin
        score_d = sum;
        max_d   = 1'b0;
      end
    end
  end

  assign bus.score_bcd = score_q;
  assign bus.score_max = max_q;

endmodule

// File: tb/tb_player_status.sv
// Directed bench for player_status: handwritten HP
// sequences plus a table of score vectors.
module tb_player_status;

  logic Clk = 1'b0;
  logic Reset;
  int   total = 0;
  int   bad   = 0;

  player_status_if bus();

  player_status dut (
    .Clk  (Clk),
    .Reset(Reset),
    .bus  (bus)
  );

  always #5 Clk = ~Clk;

  typedef struct {
    logic        gr;
    logic        sr;
    logic        pts;
    logic [3:0]  pval;
    logic [15:0] exp_score;
    logic        exp_max;
  } vec_t;

  vec_t vecs[12];

  task automatic clr();
    bus.game_reset  = 1'b0;
    bus.score_reset = 1'b0;
    bus.frame_tick  = 1'b0;
    bus.hit_1       = 1'b0;
    bus.hit_2       = 1'b0;
    bus.points      = 1'b0;
    bus.points_val  = 4'd0;
  endtask

  task automatic cyc();
    @(posedge Clk);
    #1;
    clr();
  endtask

  task automatic chk(input string nm,
                     input logic [15:0] act,
                     input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic ticks(input int n, input logic h1,
                       input logic h2);
    for (int i = 0; i < n; i++) begin
      bus.frame_tick = 1'b1;
      bus.hit_1      = h1;
      bus.hit_2      = h2;
      cyc();
    end
  endtask

  task automatic hit_window(input logic h1, input logic h2);
    bus.hit_1 = h1;
    bus.hit_2 = h2;
    cyc();
    ticks(60, 1'b0, 1'b0);
  endtask

  task automatic award(input logic [3:0] v);
    bus.points     = 1'b1;
    bus.points_val = v;
    cyc();
  endtask

  initial begin
    vecs[0]  = '{1'b0, 1'b0, 1'b1, 4'd7,  16'h0007, 1'b0};
    vecs[1]  = '{1'b0, 1'b0, 1'b1, 4'd5,  16'h0012, 1'b0};
    vecs[2]  = '{1'b0, 1'b0, 1'b1, 4'd12, 16'h0021, 1'b0};
    vecs[3]  = '{1'b0, 1'b0, 1'b1, 4'd0,  16'h0021, 1'b0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 4'd9,  16'h0021, 1'b0};
    vecs[5]  = '{1'b1, 1'b0, 1'b1, 4'd15, 16'h0030, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 4'd9,  16'h0039, 1'b0};
    vecs[7]  = '{1'b0, 1'b0, 1'b1, 4'd1,  16'h0040, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b1, 4'd9,  16'h0000, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0};
    vecs[10] = '{1'b0, 1'b0, 1'b1, 4'd3,  16'h0003, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 4'd0,  16'h0000, 1'b0};

    clr();
    Reset = 1'b1;
    repeat (3) cyc();
    Reset = 1'b0;
    cyc();
    chk("rst hp_1", 16'(bus.hp_1), 16'd5);
    chk("rst hp_2", 16'(bus.hp_2), 16'd5);
    chk("rst dead", 16'({bus.dead_1, bus.dead_2}), 16'd0);
    chk("rst inv", 16'({bus.invuln_1, bus.invuln_2}), 16'd0);
    chk("rst score", bus.score_bcd, 16'h0000);
    chk("rst max", 16'(bus.score_max), 16'd0);

    repeat (5) cyc();
    bus.hit_1 = 1'b1;
    cyc();
    chk("hit1 hp", 16'(bus.hp_1), 16'd4);
    chk("hit1 inv", 16'(bus.invuln_1), 16'd1);
    ticks(59, 1'b1, 1'b0);
    chk("inv59 hp", 16'(bus.hp_1), 16'd4);
    chk("inv59 inv", 16'(bus.invuln_1), 16'd1);
    ticks(1, 1'b1, 1'b0);
    chk("expire hp", 16'(bus.hp_1), 16'd4);
    chk("expire inv", 16'(bus.invuln_1), 16'd0);
    bus.hit_1 = 1'b1;
    cyc();
    chk("hit1b hp", 16'(bus.hp_1), 16'd3);
    chk("hit1b inv", 16'(bus.invuln_1), 16'd1);
    bus.game_reset = 1'b1;
    cyc();
    chk("gr p1 hp", 16'(bus.hp_1), 16'd5);
    chk("gr p1 inv", 16'(bus.invuln_1), 16'd0);

    repeat (4) hit_window(1'b0, 1'b1);
    chk("p2 hp1", 16'(bus.hp_2), 16'd1);
    chk("p2 alive", 16'({bus.dead_2, bus.invuln_2}), 16'd0);
    bus.hit_2 = 1'b1;
    cyc();
    chk("p2 hp0", 16'(bus.hp_2), 16'd0);
    chk("p2 dead", 16'(bus.dead_2), 16'd1);
    chk("p2 noinv", 16'(bus.invuln_2), 16'd0);
    ticks(5, 1'b0, 1'b1);
    chk("p2 dead hp", 16'(bus.hp_2), 16'd0);
    chk("p2 stays", 16'(bus.dead_2), 16'd1);
    chk("p1 alive", 16'(bus.dead_1), 16'd0);
    bus.game_reset = 1'b1;
    cyc();
    chk("gr p2 hp", 16'(bus.hp_2), 16'd5);
    chk("gr p2 dead", 16'(bus.dead_2), 16'd0);

    bus.hit_1      = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    chk("sim hp", 16'(bus.hp_1), 16'd4);
    chk("sim inv", 16'(bus.invuln_1), 16'd1);
    ticks(59, 1'b0, 1'b0);
    chk("sim 59", 16'(bus.invuln_1), 16'd1);
    ticks(1, 1'b0, 1'b0);
    chk("sim 60", 16'(bus.invuln_1), 16'd0);
    bus.hit_1      = 1'b1;
    bus.frame_tick = 1'b1;
    cyc();
    chk("sim2 hp", 16'(bus.hp_1), 16'd3);
    ticks(10, 1'b0, 1'b0);
    chk("mid inv", 16'(bus.invuln_1), 16'd1);
    bus.game_reset = 1'b1;
    cyc();
    chk("mid gr inv", 16'(bus.invuln_1), 16'd0);
    chk("mid gr hp", 16'(bus.hp_1), 16'd5);

    for (int i = 0; i < 12; i++) begin
      bus.game_reset  = vecs[i].gr;
      bus.score_reset = vecs[i].sr;
      bus.points      = vecs[i].pts;
      bus.points_val  = vecs[i].pval;
      cyc();
      chk($sformatf("vec%0d score", i),
          bus.score_bcd, vecs[i].exp_score);
      chk($sformatf("vec%0d max", i),
          16'(bus.score_max), 16'(vecs[i].exp_max));
    end

    for (int i = 0; i < 1110; i++) award(4'd9);
    chk("sat 9990", bus.score_bcd, 16'h9990);
    chk("sat 9990 max", 16'(bus.score_max), 16'd0);
    award(4'd5);
    chk("sat 9995", bus.score_bcd, 16'h9995);
    award(4'd9);
    chk("sat top", bus.score_bcd, 16'h9999);
    chk("sat max", 16'(bus.score_max), 16'd1);
    award(4'd4);
    chk("sat hold", bus.score_bcd, 16'h9999);
    chk("sat hold max", 16'(bus.score_max), 16'd1);
    bus.score_reset = 1'b1;
    bus.points      = 1'b1;
    bus.points_val  = 4'd9;
    cyc();
    chk("sr score", bus.score_bcd, 16'h0000);
    chk("sr max", 16'(bus.score_max), 16'd0);

    award(4'd6);
    repeat (4) hit_window(1'b1, 1'b1);
    bus.hit_1 = 1'b1;
    bus.hit_2 = 1'b1;
    cyc();
    chk("both dead", 16'({bus.dead_1, bus.dead_2}), 16'b11);
    award(4'd9);
    chk("dead score", bus.score_bcd, 16'h0006);
    chk("dead still", 16'({bus.dead_1, bus.dead_2}), 16'b11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
